// File: rtl/alu_pkg.sv
// Shared constants for the registered ALU: opcode encodings and flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_MOVB = 3'b110;
  localparam logic [2:0] OP_MVNB = 3'b111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // True for the opcodes whose C/V flags come from the adder.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/opcode bundle in, registered result/flags out.
interface alu_if #(
  parameter int unsigned WIDTH = 5
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       bshift;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] Result;
  logic [3:0]       ALUFlags;

  modport master (
    output a, b, bshift, ALUControl,
    input  Result, ALUFlags
  );

  modport slave (
    input  a, b, bshift, ALUControl,
    output Result, ALUFlags
  );
endinterface

// File: rtl/alu_core.sv
// Combinational pre-shifter, ALU and NZCV flag generation.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       bshift_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o
);

  logic [WIDTH-1:0] bs;
  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Shifted operand, adder shared by ADD, SUB and SLT.
  always_comb begin
    bs       = b_i << bshift_i;
    sub      = (op_i == OP_SUB) || (op_i == OP_SLT);
    b_eff    = sub ? ~bs : bs;
    sum_full = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    sum      = sum_full[WIDTH-1:0];
    cout     = sum_full[WIDTH];
    // Operand signs agree but the sum sign differs.
    ovf      = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
  end

  // Opcode mux and flag derivation; every opcode is decoded.
  always_comb begin
    result_o = '0;
    flags_o  = '0;
    unique case (op_i)
      OP_ADD:  result_o = sum;
      OP_SUB:  result_o = sum;
      OP_AND:  result_o = a_i & bs;
      OP_OR:   result_o = a_i | bs;
      OP_XOR:  result_o = a_i ^ bs;
      // N^V of the subtraction gives the overflow-correct signed compare.
      OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      OP_MOVB: result_o = bs;
      OP_MVNB: result_o = ~bs;
      default: result_o = '0;
    endcase
    flags_o[FLAG_N] = result_o[WIDTH-1];
    flags_o[FLAG_Z] = (result_o == '0);
    flags_o[FLAG_C] = is_arith(op_i) ? cout : 1'b0;
    flags_o[FLAG_V] = is_arith(op_i) ? ovf : 1'b0;
  end

endmodule

// File: rtl/alu_top.sv
// Registered ALU: combinational core followed by one result/flags register stage.
module alu_top
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);

  logic [WIDTH-1:0] result_d, result_q;
  logic [3:0]       flags_d, flags_q;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a_i      (bus.a),
    .b_i      (bus.b),
    .bshift_i (bus.bshift),
    .op_i     (bus.ALUControl),
    .result_o (result_d),
    .flags_o  (flags_d)
  );

  // Output register; reset clears immediately, discarding any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.Result   = result_q;
  assign bus.ALUFlags = flags_q;

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top: directed vectors, reset behaviour, random back-to-back ops.
module tb_alu_top;

  localparam int unsigned W = 5;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  alu_if #(.WIDTH(W)) bus ();

  alu_top #(
    .WIDTH(W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic [1:0] sh;
    logic [2:0] op;
    logic [4:0] res;
    logic [3:0] fl;
  } vec_t;

  // Reference model in plain integer arithmetic: signed/unsigned ranges, not gates.
  function automatic void model(input logic [4:0] a, input logic [4:0] b, input logic [1:0] sh,
                                input logic [2:0] op, output logic [4:0] res,
                                output logic [3:0] fl);
    int ia, bsv, sa, sb, r, sr;
    bit c, v;
    ia  = int'(a);
    bsv = (int'(b) << int'(sh)) % 32;
    sa  = (ia >= 16) ? ia - 32 : ia;
    sb  = (bsv >= 16) ? bsv - 32 : bsv;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      3'd0: begin
        r  = ia + bsv;
        c  = (r >= 32);
        sr = sa + sb;
        v  = (sr > 15) || (sr < -16);
        r  = r % 32;
      end
      3'd1: begin
        r  = (ia - bsv + 32) % 32;
        c  = (ia >= bsv);
        sr = sa - sb;
        v  = (sr > 15) || (sr < -16);
      end
      3'd2: r = ia & bsv;
      3'd3: r = ia | bsv;
      3'd4: r = ia ^ bsv;
      3'd5: r = (sa < sb) ? 1 : 0;
      3'd6: r = bsv;
      default: r = 31 - bsv;
    endcase
    res = r[4:0];
    fl  = {r >= 16, r == 0, c, v};
  endfunction

  task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic [1:0] sh,
                       input logic [2:0] op);
    bus.a          = a;
    bus.b          = b;
    bus.bshift     = sh;
    bus.ALUControl = op;
  endtask

  task automatic test_reset();
    // Load a nonzero result, then drop reset between edges.
    @(negedge clk);
    drive(5'd3, 5'd5, 2'd0, 3'b000);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.Result !== 5'd0) begin
      n_err++;
      $display("FAIL reset_async_result: got %b want 00000", bus.Result);
    end
    n_cmp++;
    if (bus.ALUFlags !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_async_flags: got %b want 0000", bus.ALUFlags);
    end
    // Held in reset across an edge with live inputs.
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.Result !== 5'd0 || bus.ALUFlags !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_held: got %b/%b want 00000/0000", bus.Result, bus.ALUFlags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(5'd12, 5'd4, 2'd0, 3'b000);
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.Result !== 5'b10000 || bus.ALUFlags !== 4'b1001) begin
      n_err++;
      $display("FAIL reset_release: got %b/%b want 10000/1001", bus.Result, bus.ALUFlags);
    end
  endtask

  task automatic test_directed();
    vec_t vecs [7];
    vecs[0] = '{a: 5'd3,     b: 5'd5,     sh: 2'd1, op: 3'b000, res: 5'b01101, fl: 4'b0000};
    vecs[1] = '{a: 5'd12,    b: 5'd4,     sh: 2'd0, op: 3'b000, res: 5'b10000, fl: 4'b1001};
    vecs[2] = '{a: 5'd7,     b: 5'd7,     sh: 2'd0, op: 3'b001, res: 5'b00000, fl: 4'b0110};
    vecs[3] = '{a: 5'd0,     b: 5'b11001, sh: 2'd3, op: 3'b110, res: 5'b01000, fl: 4'b0000};
    vecs[4] = '{a: 5'd0,     b: 5'b11001, sh: 2'd3, op: 3'b111, res: 5'b10111, fl: 4'b1000};
    vecs[5] = '{a: 5'b11101, b: 5'd2,     sh: 2'd0, op: 3'b101, res: 5'b00001, fl: 4'b0000};
    vecs[6] = '{a: 5'd2,     b: 5'b11101, sh: 2'd0, op: 3'b101, res: 5'b00000, fl: 4'b0100};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].op);
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.Result !== vecs[i].res) begin
        n_err++;
        $display("FAIL directed%0d_result: got %b want %b", i, bus.Result, vecs[i].res);
      end
      n_cmp++;
      if (bus.ALUFlags !== vecs[i].fl) begin
        n_err++;
        $display("FAIL directed%0d_flags: got %b want %b", i, bus.ALUFlags, vecs[i].fl);
      end
    end
  endtask

  task automatic test_back_to_back(input int n);
    logic [4:0] a, b, er;
    logic [1:0] sh;
    logic [2:0] op;
    logic [3:0] ef;
    for (int i = 0; i < n; i++) begin
      a  = 5'($urandom);
      b  = 5'($urandom);
      sh = 2'($urandom);
      op = 3'($urandom);
      // Bias some operands onto the signed/unsigned wrap points.
      if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) == 0) ? 5'h0f : 5'h10;
      if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 0) ? 5'h1f : 5'h01;
      model(a, b, sh, op, er, ef);
      @(negedge clk);
      drive(a, b, sh, op);
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.Result !== er || bus.ALUFlags !== ef) begin
        n_err++;
        $display("FAIL rand%0d a=%b b=%b sh=%0d op=%b: got %b/%b want %b/%b",
                 i, a, b, sh, op, bus.Result, bus.ALUFlags, er, ef);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    drive(5'd0, 5'd0, 2'd0, 3'b000);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.Result !== 5'd0 || bus.ALUFlags !== 4'b0000) begin
      n_err++;
      $display("FAIL power_on_reset: got %b/%b want 00000/0000", bus.Result, bus.ALUFlags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_directed();
    test_reset();
    test_back_to_back(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
